// File: rtl/preg_free_list.sv
// Physical register free list with ROB tag counter and one branch checkpoint.
// Optional FREELIST_DUP_CHECK_EN adds a sticky duplicate alloc/free detector.
module preg_free_list #(
  parameter int PREG_WIDTH = 7,
  parameter int AREG_COUNT = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_alloc_req,
  input  logic                  i_alloc_is_branch,
  output logic                  o_alloc_valid,
  output logic [PREG_WIDTH-1:0] o_alloc_preg,
  output logic [ROB_WIDTH-1:0]  o_alloc_tag,
  input  logic                  i_commit_valid,
  input  logic [PREG_WIDTH-1:0] i_commit_old_preg,
  input  logic                  i_branch_mispredict,
  output logic [PREG_WIDTH-1:0] o_free_count,
  output logic                  o_err
);

  localparam int NUM_PREG  = 1 << PREG_WIDTH;
  localparam int LIST_SIZE = NUM_PREG - AREG_COUNT;
  localparam int CW        = PREG_WIDTH + 2;

  typedef logic [PREG_WIDTH-1:0] idx_t;

  idx_t                 list_q [LIST_SIZE];
  idx_t                 head_q, head_d;
  idx_t                 tail_q;
  idx_t                 ckpt_head_q, ckpt_head_d;
  idx_t                 count_q, count_d;
  idx_t                 spec_q, spec_d;
  logic [ROB_WIDTH-1:0] tag_q, tag_d;
  logic [ROB_WIDTH-1:0] ckpt_tag_q, ckpt_tag_d;
  logic [CW-1:0]        count_sum;
  logic                 alloc_fire;
  logic                 free_fire;

  function automatic idx_t wrap_inc(input idx_t p);
    return (p == idx_t'(LIST_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_alloc_valid = (count_q != '0);
  assign o_alloc_preg  = list_q[head_q];
  assign o_alloc_tag   = tag_q;
  assign o_free_count  = count_q;

  assign alloc_fire = i_alloc_req & o_alloc_valid
                    & ~i_branch_mispredict;
  assign free_fire  = i_commit_valid
                    & (i_commit_old_preg != '0);

  always_comb begin
    head_d      = head_q;
    tag_d       = tag_q;
    spec_d      = spec_q;
    ckpt_head_d = ckpt_head_q;
    ckpt_tag_d  = ckpt_tag_q;
    unique case (1'b1)
      i_branch_mispredict: begin
        head_d = ckpt_head_q;
        tag_d  = ckpt_tag_q;
        spec_d = '0;
      end
      alloc_fire: begin
        head_d = wrap_inc(head_q);
        tag_d  = tag_q + 1'b1;
        if (i_alloc_is_branch) begin
          ckpt_head_d = head_d;
          ckpt_tag_d  = tag_d;
          spec_d      = '0;
        end else if (spec_q != idx_t'(LIST_SIZE)) begin
          spec_d = spec_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Rollback returns the speculative allocations; clamp keeps the count sane.
  always_comb begin
    count_sum = CW'(count_q) + CW'(free_fire) - CW'(alloc_fire);
    if (i_branch_mispredict)
      count_sum = count_sum + CW'(spec_q);
    count_d = (count_sum > CW'(LIST_SIZE))
            ? idx_t'(LIST_SIZE) : count_sum[PREG_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LIST_SIZE; i++)
        list_q[i] <= idx_t'(AREG_COUNT + i);
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= idx_t'(LIST_SIZE);
      spec_q      <= '0;
      tag_q       <= '0;
      ckpt_head_q <= '0;
      ckpt_tag_q  <= '0;
    end else begin
      if (free_fire) begin
        list_q[tail_q] <= i_commit_old_preg;
        tail_q         <= wrap_inc(tail_q);
      end
      head_q      <= head_d;
      count_q     <= count_d;
      spec_q      <= spec_d;
      tag_q       <= tag_d;
      ckpt_head_q <= ckpt_head_d;
      ckpt_tag_q  <= ckpt_tag_d;
    end
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [NUM_PREG-1:0] in_list_q, in_list_d;
  logic                err_q, err_d;

  always_comb begin
    in_list_d = in_list_q;
    err_d     = err_q;
    if (alloc_fire) begin
      if (!in_list_q[o_alloc_preg]) err_d = 1'b1;
      in_list_d[o_alloc_preg] = 1'b0;
    end
    if (free_fire) begin
      if (in_list_q[i_commit_old_preg]) err_d = 1'b1;
      in_list_d[i_commit_old_preg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_list_q <= {{LIST_SIZE{1'b1}}, {AREG_COUNT{1'b0}}};
      err_q     <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_q     <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed scenarios plus a
// randomized run against a queue-based free list model.
module tb_preg_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_alloc_req;
  logic       i_alloc_is_branch;
  logic       o_alloc_valid;
  logic [6:0] o_alloc_preg;
  logic [3:0] o_alloc_tag;
  logic       i_commit_valid;
  logic [6:0] i_commit_old_preg;
  logic       i_branch_mispredict;
  logic [6:0] o_free_count;
  logic       o_err;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  preg_free_list dut (
    .clk                 (clk),
    .reset               (reset),
    .i_alloc_req         (i_alloc_req),
    .i_alloc_is_branch   (i_alloc_is_branch),
    .o_alloc_valid       (o_alloc_valid),
    .o_alloc_preg        (o_alloc_preg),
    .o_alloc_tag         (o_alloc_tag),
    .i_commit_valid      (i_commit_valid),
    .i_commit_old_preg   (i_commit_old_preg),
    .i_branch_mispredict (i_branch_mispredict),
    .o_free_count        (o_free_count),
    .o_err               (o_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_alloc_req         = 1'b0;
    i_alloc_is_branch   = 1'b0;
    i_commit_valid      = 1'b0;
    i_commit_old_preg   = '0;
    i_branch_mispredict = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (o_alloc_valid !== 1'b1)
      $display("FAIL reset_valid got %b want 1", o_alloc_valid);
    else passed++;
    total++;
    if (o_alloc_preg !== 7'd32)
      $display("FAIL reset_preg got %0d want 32", o_alloc_preg);
    else passed++;
    total++;
    if (o_alloc_tag !== 4'd0)
      $display("FAIL reset_tag got %0d want 0", o_alloc_tag);
    else passed++;
    total++;
    if (o_free_count !== 7'd96)
      $display("FAIL reset_count got %0d want 96", o_free_count);
    else passed++;
    total++;
    if (o_err !== 1'b0)
      $display("FAIL reset_err got %b want 0", o_err);
    else passed++;
  endtask

  task automatic test_alloc_basic;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o_alloc_preg !== 7'(32 + i))
        $display("FAIL basic_preg%0d got %0d want %0d",
                 i, o_alloc_preg, 32 + i);
      else passed++;
      total++;
      if (o_alloc_tag !== 4'(i))
        $display("FAIL basic_tag%0d got %0d want %0d",
                 i, o_alloc_tag, i);
      else passed++;
      i_alloc_req = 1'b1;
      tick();
      i_alloc_req = 1'b0;
    end
    total++;
    if (o_free_count !== 7'd93)
      $display("FAIL basic_count got %0d want 93", o_free_count);
    else passed++;
  endtask

  task automatic test_empty;
    test_reset();
    i_alloc_req = 1'b1;
    repeat (96) tick();
    total++;
    if (o_alloc_valid !== 1'b0 || o_free_count !== 7'd0)
      $display("FAIL empty_state got v=%b c=%0d want v=0 c=0",
               o_alloc_valid, o_free_count);
    else passed++;
    tick();
    i_alloc_req = 1'b0;
    total++;
    if (o_alloc_tag !== 4'd0 || o_free_count !== 7'd0)
      $display("FAIL empty_ignore got t=%0d c=%0d want t=0 c=0",
               o_alloc_tag, o_free_count);
    else passed++;
    i_commit_valid    = 1'b1;
    i_commit_old_preg = 7'd5;
    tick();
    idle();
    total++;
    if (o_alloc_valid !== 1'b1 || o_alloc_preg !== 7'd5 ||
        o_free_count !== 7'd1)
      $display("FAIL empty_refill got v=%b p=%0d c=%0d want 1 5 1",
               o_alloc_valid, o_alloc_preg, o_free_count);
    else passed++;
  endtask

  task automatic test_same_cycle;
    test_reset();
    i_alloc_req       = 1'b1;
    i_commit_valid    = 1'b1;
    i_commit_old_preg = 7'd40;
    tick();
    total++;
    if (o_free_count !== 7'd96 || o_alloc_preg !== 7'd33)
      $display("FAIL same_cycle got c=%0d p=%0d want 96 33",
               o_free_count, o_alloc_preg);
    else passed++;
    i_alloc_req       = 1'b0;
    i_commit_old_preg = 7'd0;
    tick();
    i_commit_valid = 1'b0;
    total++;
    if (o_free_count !== 7'd96 || o_alloc_preg !== 7'd33 ||
        o_alloc_tag !== 4'd1)
      $display("FAIL commit_p0 got c=%0d p=%0d t=%0d want 96 33 1",
               o_free_count, o_alloc_preg, o_alloc_tag);
    else passed++;
    i_alloc_req = 1'b1;
    repeat (95) tick();
    i_alloc_req = 1'b0;
    total++;
    if (o_alloc_preg !== 7'd40 || o_free_count !== 7'd1)
      $display("FAIL tail_append got p=%0d c=%0d want 40 1",
               o_alloc_preg, o_free_count);
    else passed++;
  endtask

  task automatic test_mispredict;
    test_reset();
    i_alloc_req       = 1'b1;
    i_alloc_is_branch = 1'b1;
    tick();
    i_alloc_is_branch = 1'b0;
    repeat (4) tick();
    i_alloc_req = 1'b0;
    total++;
    if (o_alloc_preg !== 7'd37 || o_free_count !== 7'd91)
      $display("FAIL pre_flush got p=%0d c=%0d want 37 91",
               o_alloc_preg, o_free_count);
    else passed++;
    i_branch_mispredict = 1'b1;
    tick();
    i_branch_mispredict = 1'b0;
    total++;
    if (o_alloc_preg !== 7'd33 || o_alloc_tag !== 4'd1 ||
        o_free_count !== 7'd95)
      $display("FAIL flush got p=%0d t=%0d c=%0d want 33 1 95",
               o_alloc_preg, o_alloc_tag, o_free_count);
    else passed++;
  endtask

  task automatic test_flush_collision;
    i_alloc_req = 1'b1;
    repeat (3) tick();
    i_alloc_req = 1'b0;
    total++;
    if (o_free_count !== 7'd92 || o_alloc_tag !== 4'd4)
      $display("FAIL coll_pre got c=%0d t=%0d want 92 4",
               o_free_count, o_alloc_tag);
    else passed++;
    i_alloc_req         = 1'b1;
    i_branch_mispredict = 1'b1;
    i_commit_valid      = 1'b1;
    i_commit_old_preg   = 7'd50;
    tick();
    i_alloc_req    = 1'b0;
    i_commit_valid = 1'b0;
    total++;
    if (o_alloc_preg !== 7'd33 || o_alloc_tag !== 4'd1 ||
        o_free_count !== 7'd96)
      $display("FAIL coll got p=%0d t=%0d c=%0d want 33 1 96",
               o_alloc_preg, o_alloc_tag, o_free_count);
    else passed++;
    tick();
    i_branch_mispredict = 1'b0;
    total++;
    if (o_alloc_preg !== 7'd33 || o_alloc_tag !== 4'd1 ||
        o_free_count !== 7'd96)
      $display("FAIL b2b_flush got p=%0d t=%0d c=%0d want 33 1 96",
               o_alloc_preg, o_alloc_tag, o_free_count);
    else passed++;
  endtask

  task automatic test_dup;
    logic exp_err;
`ifdef FREELIST_DUP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    test_reset();
    i_commit_valid    = 1'b1;
    i_commit_old_preg = 7'd60;
    repeat (2) tick();
    idle();
    repeat (3) tick();
    total++;
    if (o_err !== exp_err)
      $display("FAIL dup_err got %b want %b", o_err, exp_err);
    else passed++;
  endtask

  task automatic test_random;
    int fl[$];
    int sq[$];
    int safe[$];
    int tag_m, ckt, idx, p;
    bit have_ck;
    test_reset();
    for (int i = 0; i < 96; i++) fl.push_back(32 + i);
    tag_m = 0;
    ckt = 0;
    have_ck = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      total++;
      if (o_alloc_valid !== (fl.size() != 0))
        $display("FAIL rnd_valid c%0d got %b want %b",
                 cyc, o_alloc_valid, fl.size() != 0);
      else passed++;
      if (fl.size() != 0) begin
        total++;
        if (o_alloc_preg !== 7'(fl[0]))
          $display("FAIL rnd_preg c%0d got %0d want %0d",
                   cyc, o_alloc_preg, fl[0]);
        else passed++;
      end
      total++;
      if (o_alloc_tag !== 4'(tag_m))
        $display("FAIL rnd_tag c%0d got %0d want %0d",
                 cyc, o_alloc_tag, tag_m);
      else passed++;
      total++;
      if (o_free_count !== 7'(fl.size()))
        $display("FAIL rnd_count c%0d got %0d want %0d",
                 cyc, o_free_count, fl.size());
      else passed++;

      i_alloc_req         = ($urandom_range(0, 99) < 70);
      i_alloc_is_branch   = ($urandom_range(0, 5) == 0);
      i_branch_mispredict = have_ck && ($urandom_range(0, 24) == 0);
      i_commit_valid      = 1'b0;
      i_commit_old_preg   = '0;
      if ($urandom_range(0, 2) == 0) begin
        i_commit_valid = 1'b1;
        if (safe.size() > 0 && $urandom_range(0, 9) != 0) begin
          idx = $urandom_range(0, safe.size() - 1);
          i_commit_old_preg = 7'(safe[idx]);
          safe.delete(idx);
        end
      end

      if (i_branch_mispredict) begin
        fl = {sq, fl};
        sq.delete();
        tag_m = ckt;
      end else if (i_alloc_req && fl.size() != 0) begin
        p = fl.pop_front();
        if (i_alloc_is_branch) begin
          safe = {safe, sq};
          safe.push_back(p);
          sq.delete();
          ckt = (tag_m + 1) % 16;
          have_ck = 1;
        end else begin
          sq.push_back(p);
        end
        tag_m = (tag_m + 1) % 16;
      end
      if (i_commit_valid && i_commit_old_preg != 0)
        fl.push_back(int'(i_commit_old_preg));
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_alloc_basic();
    test_empty();
    test_same_cycle();
    test_mispredict();
    test_flush_collision();
    test_dup();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
